// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-segment scan readback: sample, stability filter, decode to four digit registers.
// Optional macro SEG_HEX_EN adds the A..F glyphs to the decode table.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  a,
  input  logic [6:0]  c,
  output logic [15:0] digits,
  output logic [3:0]  dvalid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err_seg,
  output logic        err_an,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    s_a;
  logic [6:0]    s_c;
  logic [CW-1:0] cnt;
  logic          chg;
  logic [TW-1:0] tcnt;
  logic          blank, accept, single;
  logic [1:0]    idx;
  logic [4:0]    dec;
  logic [3:0]    cur;

  // Returns {legal, value}; illegal patterns decode to 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
`ifdef SEG_HEX_EN
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
`endif
      default:    decode = {1'b0, 4'hF};
    endcase
  endfunction

  // chg marks that s took a new value on the last edge; cnt is the run length of s.
  always_ff @(posedge clk) begin
    if (clr) begin
      s_a <= 4'hF;
      s_c <= 7'h7F;
      cnt <= '0;
      chg <= 1'b0;
    end else begin
      s_a <= a;
      s_c <= c;
      chg <= ({a, c} != {s_a, s_c});
      if ({a, c} != {s_a, s_c})
        cnt <= CW'(1);
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
    end
  end

  assign blank  = (s_a == 4'hF);
  assign accept = !blank && (cnt == CMAX) && (state != HOLD || chg);
  assign dec    = decode(s_c);
  assign cur    = digits[{idx, 2'b00} +: 4];
  assign stale  = (tcnt == TMAX);

  always_comb begin
    single = 1'b1;
    idx    = 2'd0;
    case (s_a)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = SETTLE;
    if (blank)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = HOLD;
    else if (state == HOLD && !chg)
      state_nxt = HOLD;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      digits  <= 16'hFFFF;
      dvalid  <= 4'h0;
      upd     <= 1'b0;
      upd_idx <= 2'd0;
      err_seg <= 1'b0;
      err_an  <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      upd     <= 1'b0;
      err_seg <= 1'b0;
      err_an  <= 1'b0;
      if (accept) begin
        tcnt <= '0;
        if (single) begin
          digits[{idx, 2'b00} +: 4] <= dec[3:0];
          dvalid[idx]               <= dec[4];
          err_seg                   <= !dec[4];
          if (dec[3:0] != cur) begin
            upd     <= 1'b1;
            upd_idx <= idx;
          end
        end else begin
          err_an <= 1'b1;
        end
      end else if (tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed bench with a run-length reference model of seg_scan_decoder.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 20;
`ifdef SEG_HEX_EN
  localparam int HEX_MAX = 15;
`else
  localparam int HEX_MAX = 9;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  a = 4'hF;
  logic [6:0]  c = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  dvalid;
  logic        upd, err_seg, err_an, stale;
  logic [1:0]  upd_idx;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .a(a), .c(c), .digits(digits), .dvalid(dvalid),
    .upd(upd), .upd_idx(upd_idx), .err_seg(err_seg), .err_an(err_an), .stale(stale)
  );

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an input value seen for STABLE consecutive samples is accepted one edge later.
  logic [3:0]  m_dig [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0]  m_dv = 4'h0;
  bit          m_upd = 0, m_es = 0, m_ea = 0;
  int          m_idx = 0;
  int          m_tc = 0;
  logic [10:0] m_prev = 11'h7FF;
  int          m_run = 0;
  bit          m_pend = 0;
  int          edges = 0;

  always @(posedge clk) begin : model
    int          d;
    logic [3:0]  nv;
    bit          leg;
    logic [10:0] x;
    edges++;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
      m_dv = 4'h0; m_upd = 0; m_es = 0; m_ea = 0; m_idx = 0;
      m_tc = 0; m_prev = 11'h7FF; m_run = 0; m_pend = 0;
    end else begin
      m_upd = 0; m_es = 0; m_ea = 0;
      if (m_pend) begin
        m_tc = 0;
        if ($countones(~m_prev[10:7]) == 1) begin
          d = 0;
          for (int i = 0; i < 4; i++) if (!m_prev[7+i]) d = i;
          nv = 4'hF; leg = 0;
          for (int v = 0; v <= HEX_MAX; v++)
            if (m_prev[6:0] == pat[v]) begin nv = 4'(v); leg = 1; end
          if (nv != m_dig[d]) begin m_upd = 1; m_idx = d; end
          m_dig[d] = nv;
          m_dv[d]  = leg;
          m_es     = !leg;
        end else begin
          m_ea = 1;
        end
      end else begin
        m_tc++;
      end
      x = {a, c};
      if (x != m_prev) m_run = 1; else m_run++;
      m_prev = x;
      m_pend = (m_run == STABLE) && (x[10:7] != 4'hF);
    end
  end

  int n_upd = 0, n_es = 0, n_ea = 0;
  int idxq[$];

  always @(negedge clk) begin
    if (edges > 0) begin
      check("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
      check("dvalid", 32'(dvalid), 32'(m_dv));
      check("upd", 32'(upd), 32'(m_upd));
      if (m_upd) check("upd_idx", 32'(upd_idx), 32'(m_idx));
      check("err_seg", 32'(err_seg), 32'(m_es));
      check("err_an", 32'(err_an), 32'(m_ea));
      check("stale", 32'(stale), 32'(m_tc >= TMO));
      if (upd) begin n_upd++; idxq.push_back(int'(upd_idx)); end
      if (err_seg) n_es++;
      if (err_an) n_ea++;
    end
  end

  task automatic hold(input logic [3:0] av, input logic [6:0] cv, input int n);
    a = av;
    c = cv;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_digits", 32'(digits), 32'h0000FFFF);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);

    // first digit: accept lands on edge 5
    n_upd = 0; idxq.delete();
    hold(4'b1110, 7'b0010010, 4);
    check("lat_early", 32'(digits), 32'h0000FFFF);
    hold(4'b1110, 7'b0010010, 1);
    check("first_digits", 32'(digits), 32'h0000FFF2);
    check("first_upd", 32'(upd), 32'h1);
    check("first_idx", 32'(upd_idx), 32'h0);
    check("first_dvalid", 32'(dvalid), 32'h1);
    check("first_err", 32'({err_seg, err_an}), 32'h0);
    hold(4'b1110, 7'b0010010, 5);

    // scan all four digits with 9,0,7,3
    n_upd = 0; idxq.delete();
    hold(4'b1110, 7'b0000100, 10);
    hold(4'b1101, 7'b0000001, 10);
    hold(4'b1011, 7'b0001111, 10);
    hold(4'b0111, 7'b0000110, 10);
    check("scan_digits", 32'(digits), 32'h00003709);
    check("scan_dvalid", 32'(dvalid), 32'hF);
    check("scan_nupd", 32'(n_upd), 32'd4);
    if (idxq.size() == 4)
      for (int i = 0; i < 4; i++) check("scan_idx", 32'(idxq[i]), 32'(i));

    // glitch of a "1" for 3 cycles must not be accepted
    n_upd = 0; idxq.delete();
    hold(4'b1101, 7'b1001111, 3);
    hold(4'b1101, 7'b0000110, 4);
    check("glitch_early", 32'(digits[7:4]), 32'h0);
    hold(4'b1101, 7'b0000110, 6);
    check("glitch_digit", 32'(digits[7:4]), 32'h3);
    check("glitch_nupd", 32'(n_upd), 32'd1);

    // two anodes low, then an illegal pattern
    n_ea = 0; n_es = 0;
    hold(4'b1100, 7'b0000001, 6);
    check("an_count", 32'(n_ea), 32'd1);
    check("an_digits", 32'(digits), 32'h00003739);
    hold(4'b1011, 7'b1111110, 6);
    check("seg_count", 32'(n_es), 32'd1);
    check("seg_digits", 32'(digits), 32'h00003F39);
    check("seg_dvalid", 32'(dvalid), 32'hB);
    check("seg_an_count", 32'(n_ea), 32'd1);

    // stale on blank, cleared by the next accept
    hold(4'hF, 7'h7F, 25);
    check("stale_set", 32'(stale), 32'h1);
    hold(4'b1110, 7'b0000001, 4);
    check("stale_pre", 32'(stale), 32'h1);
    hold(4'hF, 7'h7F, 1);
    check("stale_clear", 32'(stale), 32'h0);
    check("stale_digit", 32'(digits[3:0]), 32'h0);

    // reset in the middle of SETTLE
    hold(4'b1101, 7'b0000001, 2);
    clr = 1'b1;
    hold(4'b1101, 7'b0000001, 1);
    clr = 1'b0;
    check("clr_digits", 32'(digits), 32'h0000FFFF);
    check("clr_dvalid", 32'(dvalid), 32'h0);
    check("clr_flags", 32'({upd, err_seg, err_an, stale}), 32'h0);

    // hex glyph A on digit 0
    n_es = 0;
    hold(4'b1110, 7'b0001000, 6);
`ifdef SEG_HEX_EN
    check("hex_a_digit", 32'(digits[3:0]), 32'hA);
    check("hex_a_dvalid", 32'(dvalid[0]), 32'h1);
    check("hex_a_err", 32'(n_es), 32'd0);
`else
    check("hex_a_digit", 32'(digits[3:0]), 32'hF);
    check("hex_a_dvalid", 32'(dvalid[0]), 32'h0);
    check("hex_a_err", 32'(n_es), 32'd1);
`endif

    // every table glyph on digit 2
    for (int v = 0; v < 16; v++) hold(4'b1011, pat[v], 6);
    hold(4'hF, 7'h7F, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
